sp_multiplier_seq: RTL and testbench

Iterative IEEE-754 single-precision multiplier for the FPU, the companion to the sequential single-precision divider. It uses the same start/done handshake and the same flag set, so the FPU issue logic drives both units identically. The mantissa product is formed by a 24-step shift-and-add loop. Rounding supports all five RISC-V modes.

---
 rtl/sp_multiplier_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_sp_multiplier_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sp_multiplier_seq.sv
// Iterative IEEE-754 single-precision multiplier with start/done handshake,
// 24-step shift-and-add mantissa product and all five RISC-V rounding modes.
module sp_multiplier_seq #(
    parameter int          MUL_BITS = 24,
    parameter logic [31:0] QNAN     = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [2:0]  rounding_mode,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    typedef enum logic [2:0] {
        IDLE, SPECIAL, NORMALIZE, MULT, ALIGN, ROUND, PACK, DONE
    } state_t;

    state_t             state;
    logic [31:0]        op_a, op_b;
    logic [2:0]         rm;
    logic               sign;
    logic [23:0]        man_a, man_b, mant;
    logic signed [9:0]  exp;
    logic [47:0]        acc;
    logic [4:0]         cnt;
    logic               g, r, s;
    logic               tiny, align_shift, inexact_r, shifted_out;

    logic [7:0]  ea, eb, ea_eff, eb_eff;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign ea     = op_a[30:23];
    assign eb     = op_b[30:23];
    assign fa     = op_a[22:0];
    assign fb     = op_b[22:0];
    assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
    assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'd0) && (fa == 23'd0);
    assign b_zero = (eb == 8'd0) && (fb == 23'd0);

    // Pick the 24 significant product bits and their guard/round/sticky tail.
    logic [23:0]       norm_mant;
    logic              norm_g, norm_r, norm_s;
    logic signed [9:0] norm_exp;

    always_comb begin
        norm_mant = acc[46:23];
        norm_g    = acc[22];
        norm_r    = acc[21];
        norm_s    = |acc[20:0];
        norm_exp  = exp;
        if (acc[47]) begin
            norm_mant = acc[47:24];
            norm_g    = acc[23];
            norm_r    = acc[22];
            norm_s    = |acc[21:0];
            norm_exp  = exp + 10'sd1;
        end
    end

    logic        inexact, round_up;
    logic [24:0] rounded;

    always_comb begin
        inexact  = g | r | s;
        round_up = 1'b0;
        case (rm)
            3'b000:  round_up = g & (mant[0] | r | s);
            3'b010:  round_up = inexact & sign;
            3'b011:  round_up = inexact & ~sign;
            3'b100:  round_up = g;
            default: round_up = 1'b0;
        endcase
        rounded = {1'b0, mant} + {24'd0, round_up};
    end

    logic overflow_to_inf;

    always_comb begin
        overflow_to_inf = (rm == 3'b000) || (rm == 3'b100) ||
                          ((rm == 3'b011) && !sign) || ((rm == 3'b010) && sign);
    end

    // Whole control path and registered outputs live in one sequential block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            result         <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
            op_a           <= 32'd0;
            op_b           <= 32'd0;
            rm             <= 3'd0;
            sign           <= 1'b0;
            man_a          <= 24'd0;
            man_b          <= 24'd0;
            mant           <= 24'd0;
            exp            <= 10'sd0;
            acc            <= 48'd0;
            cnt            <= 5'd0;
            g              <= 1'b0;
            r              <= 1'b0;
            s              <= 1'b0;
            tiny           <= 1'b0;
            align_shift    <= 1'b0;
            inexact_r      <= 1'b0;
            shifted_out    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a           <= operand_a;
                        op_b           <= operand_b;
                        rm             <= rounding_mode;
                        flag_invalid   <= 1'b0;
                        flag_overflow  <= 1'b0;
                        flag_underflow <= 1'b0;
                        flag_inexact   <= 1'b0;
                        busy           <= 1'b1;
                        state          <= SPECIAL;
                    end
                end
                SPECIAL: begin
                    sign <= op_a[31] ^ op_b[31];
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                        result       <= QNAN;
                        flag_invalid <= 1'b1;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else if (a_inf || b_inf) begin
                        result <= {op_a[31] ^ op_b[31], 8'hFF, 23'd0};
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (a_zero || b_zero) begin
                        result <= {op_a[31] ^ op_b[31], 31'd0};
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        man_a <= {ea != 8'd0, fa};
                        man_b <= {eb != 8'd0, fb};
                        exp   <= $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - 10'sd127;
                        state <= NORMALIZE;
                    end
                end
                NORMALIZE: begin
                    if (!man_a[23]) begin
                        man_a <= man_a << 1;
                        exp   <= exp - 10'sd1;
                    end else if (!man_b[23]) begin
                        man_b <= man_b << 1;
                        exp   <= exp - 10'sd1;
                    end else begin
                        acc   <= 48'd0;
                        cnt   <= 5'd0;
                        state <= MULT;
                    end
                end
                MULT: begin
                    if (man_b[cnt])
                        acc <= acc + ({24'd0, man_a} << cnt);
                    if (cnt == 5'(MUL_BITS - 1)) begin
                        align_shift <= 1'b0;
                        state       <= ALIGN;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ALIGN: begin
                    // Subnormal results are denormalised one bit per cycle.
                    if (align_shift) begin
                        mant <= mant >> 1;
                        g    <= mant[0];
                        r    <= g;
                        s    <= s | r;
                        exp  <= exp + 10'sd1;
                        if ((exp == 10'sd0) || (mant[23:1] == 23'd0)) begin
                            align_shift <= 1'b0;
                            state       <= ROUND;
                        end
                    end else begin
                        mant <= norm_mant;
                        g    <= norm_g;
                        r    <= norm_r;
                        s    <= norm_s;
                        exp  <= norm_exp;
                        tiny <= (norm_exp < 10'sd1);
                        if (norm_exp < 10'sd1)
                            align_shift <= 1'b1;
                        else
                            state <= ROUND;
                    end
                end
                ROUND: begin
                    inexact_r   <= inexact;
                    shifted_out <= (mant == 24'd0);
                    if (rounded[24]) begin
                        mant <= rounded[24:1];
                        exp  <= exp + 10'sd1;
                    end else begin
                        mant <= rounded[23:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    if (shifted_out) begin
                        result         <= {sign, 31'd0};
                        flag_underflow <= 1'b1;
                        flag_inexact   <= 1'b1;
                    end else if (exp > 10'sd254) begin
                        result        <= overflow_to_inf ? {sign, 8'hFF, 23'd0} : {sign, 31'h7F7FFFFF};
                        flag_overflow <= 1'b1;
                        flag_inexact  <= 1'b1;
                    end else begin
                        result         <= {sign, mant[23] ? exp[7:0] : 8'h00, mant[22:0]};
                        flag_inexact   <= inexact_r;
                        flag_underflow <= tiny & inexact_r;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sp_multiplier_seq.sv
// Directed self-checking bench for sp_multiplier_seq: hand-computed products,
// flags and start-to-done latencies, plus reset and start-while-busy handling.
module tb_sp_multiplier_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [2:0]  rounding_mode;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int tests_run;
    int tests_failed;

    sp_multiplier_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .rounding_mode (rounding_mode),
        .result        (result),
        .busy          (busy),
        .done          (done),
        .flag_invalid  (flag_invalid),
        .flag_overflow (flag_overflow),
        .flag_underflow(flag_underflow),
        .flag_inexact  (flag_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] flagVec();
        return {28'd0, flag_invalid, flag_overflow, flag_underflow, flag_inexact};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Latency counts the start-sampling edge as 1; optional glitch re-pulses start mid-operation.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode,
                                 input int glitch_at, output int latency, output logic busy_err,
                                 output logic timed_out);
        @(negedge clk);
        operand_a     = a;
        operand_b     = b;
        rounding_mode = mode;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        latency   = 1;
        busy_err  = !busy;
        timed_out = 1'b0;
        while (!done && !timed_out) begin
            @(posedge clk);
            #1;
            latency++;
            if (!busy) busy_err = 1'b1;
            if (latency == glitch_at) begin
                start     = 1'b1;
                operand_a = 32'h7F800000;
                operand_b = 32'h00000000;
            end else begin
                start = 1'b0;
            end
            if (latency > 300) timed_out = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] mode, input logic [31:0] exp_res,
                             input logic [3:0] exp_flags, input int exp_lat, input int glitch_at);
        int   lat;
        logic berr, tout;
        applyStimulus(a, b, mode, glitch_at, lat, berr, tout);
        if (tout) begin
            checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
        end else begin
            checkOutput({tag, "_result"}, result, exp_res);
            checkOutput({tag, "_flags"}, flagVec(), {28'd0, exp_flags});
            checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            checkOutput({tag, "_busy"}, {31'd0, berr}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
            checkOutput({tag, "_held"}, result, exp_res);
        end
    endtask

    initial begin
        int done_seen;
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        start         = 1'b0;
        operand_a     = 32'd0;
        operand_b     = 32'd0;
        rounding_mode = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_ctrl", {30'd0, busy, done}, 32'd0);
        checkOutput("reset_flags", flagVec(), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // flags order: {invalid, overflow, underflow, inexact}
        runVector("two_x_three", 32'h40000000, 32'h40400000, 3'b000, 32'h40C00000, 4'b0000, 30, 0);
        runVector("ulp_rne", 32'h3F800001, 32'h3F800001, 3'b000, 32'h3F800002, 4'b0001, 30, 0);
        runVector("ulp_rup", 32'h3F800001, 32'h3F800001, 3'b011, 32'h3F800003, 4'b0001, 30, 0);
        runVector("ulp_rtz", 32'h3F800001, 32'h3F800001, 3'b001, 32'h3F800002, 4'b0001, 30, 0);
        runVector("inf_x_zero", 32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 4'b1000, 2, 0);
        runVector("neginf_x_two", 32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 4'b0000, 2, 0);
        runVector("ovf_rne", 32'h7F7FFFFF, 32'h40000000, 3'b000, 32'h7F800000, 4'b0101, 30, 0);
        runVector("ovf_rtz", 32'h7F7FFFFF, 32'h40000000, 3'b001, 32'h7F7FFFFF, 4'b0101, 30, 0);
        runVector("ovf_neg_rup", 32'hFF7FFFFF, 32'h40000000, 3'b011, 32'hFF7FFFFF, 4'b0101, 30, 0);
        runVector("sub_exact", 32'h00800000, 32'h3F000000, 3'b000, 32'h00400000, 4'b0000, 31, 0);
        runVector("sub_inexact", 32'h00800001, 32'h3F000000, 3'b000, 32'h00400000, 4'b0011, 31, 0);
        runVector("min_x_min", 32'h00000001, 32'h00000001, 3'b000, 32'h00000000, 4'b0011, 100, 0);

        // Reset lands in the tenth MULT cycle: start edge, SPECIAL, NORMALIZE, then 9 MULT edges.
        @(negedge clk);
        operand_a     = 32'h40000000;
        operand_b     = 32'h40400000;
        rounding_mode = 3'b000;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_ctrl", {30'd0, busy, done}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_flags", flagVec(), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        checkOutput("midrst_no_done", 32'(done_seen), 32'd0);

        runVector("one_x_one", 32'h3F800000, 32'h3F800000, 3'b000, 32'h3F800000, 4'b0000, 30, 0);
        runVector("start_while_busy", 32'h3F800001, 32'h3F800001, 3'b011, 32'h3F800003, 4'b0001, 30, 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
